phase_generator_mw: RTL
=======================

Name: phase_generator_mw

Overview:
- Parametrised, fully pipelined operator phase/waveform generator. Successor to the OPL2 phase generator.
- Serves NUM_OPS time-multiplexed operators, e.g. 18 for OPL2 or 36 for OPL3 dual bank.
- Supports all eight OPL3 waveforms and tags each output with its operator number, so the downstream mixer no longer relies on fixed pipeline-delay matching.
- Sits between the per-operator register/envelope slots and the channel accumulator.

Parameters:
- NUM_OPS, 18: operators served; accumulator RAM depth.
- OP_NUM_WIDTH, 5: width of operator index; must satisfy 2**OP_NUM_WIDTH >= NUM_OPS.
- PHASE_ACC_WIDTH, 20: phase accumulator width.
- ENV_WIDTH, 9: envelope attenuation width.
- OP_OUT_WIDTH, 13: signed operator output width.
- MOD_SHIFT, 10: left shift applied to modulation before it is added to phase.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  slot inputs valid this cycle.
- in_op_num  in  OP_NUM_WIDTH  operator index.
- phase_inc  in  PHASE_ACC_WIDTH  per-sample phase increment.
- ws  in  3  waveform select.
- env  in  ENV_WIDTH  envelope attenuation (0 = loudest).
- key_on_pulse  in  1  clear this operator's phase.
- modulation  in  OP_OUT_WIDTH  phase modulation input (raw bits).
- out_valid  out  1  out is valid.
- out_op_num  out  OP_NUM_WIDTH  operator of current out.
- out  out  OP_OUT_WIDTH signed  operator sample.

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - all accumulator entries = 0; all pipeline valids = 0.
  - out = 0, out_valid = 0, out_op_num = 0.
  - Reset mid-pipeline discards in-flight samples; no out_valid for them.
- Pipeline: 4 stages; out_valid rises exactly 4 cycles after the accepted in_valid. No stall; an input is accepted every cycle.
- S0, accumulate:
  - acc = RAM[in_op_num].
  - If key_on_pulse: RAM <= 0 and p = 0.
  - Else: RAM <= (acc + phase_inc) mod 2^W, and p = (acc + phase_inc + (modulation << MOD_SHIFT)) mod 2^W.
  - Modulation is never written back to RAM.
  - The write is visible to a read of the same op on the next cycle; back-to-back same-op access is legal.
  - in_op_num >= NUM_OPS: no RAM write; output produced with acc = 0.
- Phase fields: t = p[W-1:W-10]; s = t[9] (half), q = t[8] (quarter), th = t[7:0].
- S1, waveform decode:
  - Produces log-sine index, sign neg and zero flag per ws:
  - 0 sine: idx = q ? ~th : th; neg = s.
  - 1 half-sine: as 0; zero if s.
  - 2 abs-sine: as 0; neg = 0.
  - 3 pulse-sine: as 2; zero if q.
  - 4 alt-sine: zero if s; else double frequency: idx = th[7] ? ~{th[6:0],0} : {th[6:0],0}; neg = q.
  - 5 camel: as 4 with neg = 0.
  - 6 square: log term = 0; neg = s.
  - 7 log-saw: log term = (s ? ~t[8:0] : t[8:0]) << 3; neg = s.
  - Log-sine ROM is registered.
- S2, attenuate:
  - a = logterm + (env << 3), 13-bit unsigned, saturating at 0x1FFF.
  - Exp ROM indexed by ~a[7:0], registered.
- S3, output:
  - m = ((1024 + exp) << 1) >> a[12:8].
  - m = 0 if zero flag set or a[12:8] >= 13.
  - out = neg ? ~m : m (one's-complement negative, so the negative zero is all-ones).
  - out_op_num and out_valid are registered alongside out.
- Invalid slots (in_valid=0): RAM untouched; out_valid = 0; out holds its last value.

Optional Feature:
- Macro PG_OPL3_WS_EN.
- Defined: all 8 waveforms as above.
- Undefined: ws[2] is ignored (treated as 0) and waveforms 4-7 logic is not synthesised, giving strict OPL2 behaviour.

Test Plan:
- Reset, then in_valid=0 for 10 cycles -> out=0, out_valid=0 throughout.
- op 3, phase_inc=0x400, 3 valid slots -> RAM[3] = 0x400, 0x800, 0xC00; each out_valid appears 4 cycles after its input, with out_op_num=3.
- RAM[5]=0xFFC00, phase_inc=0x800 -> RAM[5] wraps to 0x00400; key_on_pulse next slot -> RAM[5]=0 and that sample is computed with p=0.
- ws=6, env=0: p in first half -> out = +Mmax, where Mmax = 2*(1024 + expROM[255]); p in second half -> ~Mmax; env=0x1FF -> out = 0.
- ws=1 with s=1 -> out = 0; ws=3 with q=1 -> 0; ws=4/5 with s=1 -> 0. With PG_OPL3_WS_EN undefined, ws=5 gives output identical to ws=1.
- Modulation=0x100, phase_inc=0 -> p differs by 0x40000 from the unmodulated run; RAM unchanged. Assert rst_n mid-stream -> no out_valid for in-flight slots.

Source files
------------

// File: rtl/phase_generator_mw.sv
// phase_generator_mw: fully pipelined, time-multiplexed operator phase/waveform generator.
// Four register stages: accumulate -> waveform decode / log-sine ROM -> attenuate / exp ROM -> output.
// Optional macro PG_OPL3_WS_EN enables OPL3 waveforms 4-7; when undefined ws[2] is ignored (OPL2).
// ROM contents: logsin[i] = round(-log2(sin((i+0.5)*pi/512))*256),
//               exp[i]    = round((2^(i/256)-1)*1024).
module phase_generator_mw #(
    parameter int NUM_OPS         = 18,
    parameter int OP_NUM_WIDTH    = 5,
    parameter int PHASE_ACC_WIDTH = 20,
    parameter int ENV_WIDTH       = 9,
    parameter int OP_OUT_WIDTH    = 13,
    parameter int MOD_SHIFT       = 10
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    input  logic [OP_NUM_WIDTH-1:0]        in_op_num,
    input  logic [PHASE_ACC_WIDTH-1:0]     phase_inc,
    input  logic [2:0]                     ws,
    input  logic [ENV_WIDTH-1:0]           env,
    input  logic                           key_on_pulse,
    input  logic [OP_OUT_WIDTH-1:0]        modulation,
    output logic                           out_valid,
    output logic [OP_NUM_WIDTH-1:0]        out_op_num,
    output logic signed [OP_OUT_WIDTH-1:0] out
);
    localparam int  W  = PHASE_ACC_WIDTH;
    localparam real PI = 3.14159265358979323846;

    // Constant ROM tables, evaluated at elaboration time
    logic [11:0] logsin_rom [256];
    logic [9:0]  exp_rom    [256];

    genvar gi;
    generate
        for (gi = 0; gi < 256; gi++) begin : g_rom
            localparam int LS = $rtoi(-$ln($sin((gi + 0.5) * PI / 512.0)) / $ln(2.0) * 256.0 + 0.5);
            localparam int EX = $rtoi(($pow(2.0, gi / 256.0) - 1.0) * 1024.0 + 0.5);
            assign logsin_rom[gi] = 12'(LS);
            assign exp_rom[gi]    = 10'(EX);
        end
    endgenerate

    // ---------------- S0: phase accumulate ----------------
    logic [W-1:0]            ram_q [NUM_OPS];
    logic [W-1:0]            ram_d;
    logic                    ram_we;
    logic [W-1:0]            acc;
    logic [W-1:0]            mod_term;
    logic [W-1:0]            p;
    logic [9:0]              s0_t_d;
    logic [2:0]              ws_d;
    logic                    unused_p_lo;

    logic                    s0_valid_q;
    logic [OP_NUM_WIDTH-1:0] s0_op_q;
    logic [9:0]              s0_t_q;
    logic [2:0]              s0_ws_q;
    logic [ENV_WIDTH-1:0]    s0_env_q;

`ifdef PG_OPL3_WS_EN
    assign ws_d = ws;
`else
    logic unused_ws2;
    assign ws_d       = {1'b0, ws[1:0]};
    assign unused_ws2 = ws[2];
`endif

    // Read-modify-write of the operator accumulator; modulation only affects the sampled phase
    always_comb begin
        acc = '0;
        if (32'(in_op_num) < NUM_OPS) acc = ram_q[in_op_num];
        ram_we   = in_valid && (32'(in_op_num) < NUM_OPS);
        ram_d    = key_on_pulse ? '0 : acc + phase_inc;
        mod_term = W'(modulation) << MOD_SHIFT;
        p        = key_on_pulse ? '0 : acc + phase_inc + mod_term;
        s0_t_d   = p[W-1:W-10];
    end

    assign unused_p_lo = ^p[W-11:0];

    // Accumulator RAM: cleared on reset, written once per valid in-range slot
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_OPS; i++) ram_q[i] <= '0;
        end else if (ram_we) begin
            ram_q[in_op_num] <= ram_d;
        end
    end

    // S0 pipeline register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s0_valid_q <= 1'b0;
            s0_op_q    <= '0;
            s0_t_q     <= '0;
            s0_ws_q    <= '0;
            s0_env_q   <= '0;
        end else begin
            s0_valid_q <= in_valid;
            s0_op_q    <= in_op_num;
            s0_t_q     <= s0_t_d;
            s0_ws_q    <= ws_d;
            s0_env_q   <= env;
        end
    end

    // ---------------- S1: waveform decode + log-sine lookup ----------------
    logic                    ph_s, ph_q;
    logic [7:0]              th;
    logic [7:0]              idx_sine;
    logic [11:0]             s1_lt_d;
    logic                    s1_neg_d, s1_zero_d;
`ifdef PG_OPL3_WS_EN
    logic [7:0]              th2, idx_alt;
    logic [11:0]             saw;
`endif

    logic                    s1_valid_q;
    logic [OP_NUM_WIDTH-1:0] s1_op_q;
    logic [11:0]             s1_lt_q;
    logic                    s1_neg_q, s1_zero_q;
    logic [ENV_WIDTH-1:0]    s1_env_q;

    // Pick log term, sign and silence per waveform; a silenced sample is always positive zero
    always_comb begin
        ph_s      = s0_t_q[9];
        ph_q      = s0_t_q[8];
        th        = s0_t_q[7:0];
        idx_sine  = ph_q ? ~th : th;
        s1_lt_d   = logsin_rom[idx_sine];
        s1_neg_d  = ph_s;
        s1_zero_d = 1'b0;
`ifdef PG_OPL3_WS_EN
        th2       = {th[6:0], 1'b0};
        idx_alt   = th[7] ? ~th2 : th2;
        saw       = {(ph_s ? ~s0_t_q[8:0] : s0_t_q[8:0]), 3'b000};
`endif
        case (s0_ws_q)
            3'd1: s1_zero_d = ph_s;
            3'd2: s1_neg_d  = 1'b0;
            3'd3: begin
                s1_neg_d  = 1'b0;
                s1_zero_d = ph_q;
            end
`ifdef PG_OPL3_WS_EN
            3'd4: begin
                s1_zero_d = ph_s;
                s1_neg_d  = ph_q;
                s1_lt_d   = logsin_rom[idx_alt];
            end
            3'd5: begin
                s1_zero_d = ph_s;
                s1_neg_d  = 1'b0;
                s1_lt_d   = logsin_rom[idx_alt];
            end
            3'd6: s1_lt_d = '0;
            3'd7: s1_lt_d = saw;
`endif
            default: ;
        endcase
        if (s1_zero_d) s1_neg_d = 1'b0;
    end

    // S1 pipeline register (holds the registered ROM output)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_lt_q    <= '0;
            s1_neg_q   <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_env_q   <= '0;
        end else begin
            s1_valid_q <= s0_valid_q;
            s1_op_q    <= s0_op_q;
            s1_lt_q    <= s1_lt_d;
            s1_neg_q   <= s1_neg_d;
            s1_zero_q  <= s1_zero_d;
            s1_env_q   <= s0_env_q;
        end
    end

    // ---------------- S2: attenuate + exp lookup ----------------
    logic [31:0]             a_sum;
    logic [12:0]             a_d;

    logic                    s2_valid_q;
    logic [OP_NUM_WIDTH-1:0] s2_op_q;
    logic [9:0]              s2_exp_q;
    logic [4:0]              s2_sh_q;
    logic                    s2_neg_q, s2_zero_q;

    // Total attenuation in log domain, saturated to 13 bits
    always_comb begin
        a_sum = 32'(s1_lt_q) + (32'(s1_env_q) << 3);
        a_d   = (a_sum > 32'h1FFF) ? 13'h1FFF : a_sum[12:0];
    end

    // S2 pipeline register (exp ROM read is registered here)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_op_q    <= '0;
            s2_exp_q   <= '0;
            s2_sh_q    <= '0;
            s2_neg_q   <= 1'b0;
            s2_zero_q  <= 1'b0;
        end else begin
            s2_valid_q <= s1_valid_q;
            s2_op_q    <= s1_op_q;
            s2_exp_q   <= exp_rom[~a_d[7:0]];
            s2_sh_q    <= a_d[12:8];
            s2_neg_q   <= s1_neg_q;
            s2_zero_q  <= s1_zero_q;
        end
    end

    // ---------------- S3: linear magnitude + sign ----------------
    logic [11:0]             mag;
    logic [OP_OUT_WIDTH-1:0] out_d;

    logic                    out_valid_q;
    logic [OP_NUM_WIDTH-1:0] out_op_num_q;
    logic [OP_OUT_WIDTH-1:0] out_q;

    // Mantissa shifted by the integer attenuation; one's-complement for negative half
    always_comb begin
        mag = '0;
        if (!s2_zero_q && (s2_sh_q < 5'd13)) mag = {1'b1, s2_exp_q, 1'b0} >> s2_sh_q;
        out_d = s2_neg_q ? ~(OP_OUT_WIDTH'(mag)) : OP_OUT_WIDTH'(mag);
    end

    // Output register: sample and tag update only on valid slots, otherwise hold
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_op_num_q <= '0;
            out_q        <= '0;
        end else begin
            out_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                out_op_num_q <= s2_op_q;
                out_q        <= out_d;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_op_num = out_op_num_q;
    assign out        = out_q;

endmodule
